// File: rtl/muldiv_pkg.sv
// Shared op encodings, FSM states and op-decode helpers for the multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_DIV   = 4'd2,
    OP_DIVU  = 4'd3,
    OP_MADD  = 4'd4,
    OP_MADDU = 4'd5,
    OP_MSUB  = 4'd6,
    OP_MSUBU = 4'd7,
    OP_MTHI  = 4'd8,
    OP_MTLO  = 4'd9
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_e;

  function automatic logic is_mul(input logic [3:0] op);
    case (op)
      OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_mul = 1'b1;
      default: is_mul = 1'b0;
    endcase
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    case (op)
      OP_DIV, OP_DIVU: is_div = 1'b1;
      default: is_div = 1'b0;
    endcase
  endfunction

  function automatic logic is_signed(input logic [3:0] op);
    case (op)
      OP_MULT, OP_DIV, OP_MADD, OP_MSUB: is_signed = 1'b1;
      default: is_signed = 1'b0;
    endcase
  endfunction

  function automatic logic is_acc(input logic [3:0] op);
    case (op)
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_acc = 1'b1;
      default: is_acc = 1'b0;
    endcase
  endfunction

  function automatic logic is_sub(input logic [3:0] op);
    case (op)
      OP_MSUB, OP_MSUBU: is_sub = 1'b1;
      default: is_sub = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_unit_seq_divider.sv
// Restoring divider on magnitudes with sign fix-up; retires enough quotient bits
// per cycle that all WIDTH steps fit inside DIV_CYCLES busy cycles.
module seq_divider #(
  parameter int WIDTH      = 32,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_quot,
  output logic [WIDTH-1:0] o_rem
);

  localparam int BPC    = (WIDTH + DIV_CYCLES - 1) / DIV_CYCLES;
  localparam int STEP_W = $clog2(WIDTH + 1);
  localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(WIDTH);

  logic [WIDTH-1:0]  r_rem, r_quot, r_dvsr;
  logic              r_neg_q, r_neg_r;
  logic [STEP_W-1:0] r_step;

  logic [WIDTH-1:0]  w_rem, w_quot, w_dvd_mag, w_dvsr_mag;
  logic [WIDTH:0]    w_trial;
  logic [STEP_W-1:0] w_step;
  logic              w_dvd_neg, w_dvsr_neg;

  assign w_dvd_neg  = i_signed & i_dividend[WIDTH-1];
  assign w_dvsr_neg = i_signed & i_divisor[WIDTH-1];
  assign w_dvd_mag  = w_dvd_neg  ? -i_dividend : i_dividend;
  assign w_dvsr_mag = w_dvsr_neg ? -i_divisor  : i_divisor;

  // Outputs reflect this cycle's steps too, so the final busy cycle sees a finished result.
  always_comb begin
    w_rem   = r_rem;
    w_quot  = r_quot;
    w_step  = r_step;
    w_trial = {(WIDTH+1){1'b0}};
    for (int b = 0; b < BPC; b++) begin
      if (w_step < STEP_MAX) begin
        w_trial = {w_rem, w_quot[WIDTH-1]} - {1'b0, r_dvsr};
        if (!w_trial[WIDTH]) begin
          w_rem  = w_trial[WIDTH-1:0];
          w_quot = {w_quot[WIDTH-2:0], 1'b1};
        end else begin
          w_rem  = {w_rem[WIDTH-2:0], w_quot[WIDTH-1]};
          w_quot = {w_quot[WIDTH-2:0], 1'b0};
        end
        w_step = w_step + STEP_W'(1);
      end else begin
        w_step = w_step;
      end
    end
  end

  assign o_quot = r_neg_q ? -w_quot : w_quot;
  assign o_rem  = r_neg_r ? -w_rem  : w_rem;

  // Divider working registers: load magnitudes on accept, otherwise advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem   <= {WIDTH{1'b0}};
      r_quot  <= {WIDTH{1'b0}};
      r_dvsr  <= {WIDTH{1'b0}};
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_step  <= {STEP_W{1'b0}};
    end else if (i_load) begin
      r_rem   <= {WIDTH{1'b0}};
      r_quot  <= w_dvd_mag;
      r_dvsr  <= w_dvsr_mag;
      r_neg_q <= w_dvd_neg ^ w_dvsr_neg;
      r_neg_r <= w_dvd_neg;
      r_step  <= {STEP_W{1'b0}};
    end else begin
      r_rem   <= w_rem;
      r_quot  <= w_quot;
      r_step  <= w_step;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with private HI/LO for the E stage; busy drives
// the stall controller and flush cancels an in-flight op without touching HI/LO.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             flush,
  input  logic             rd_hi,
  output logic             busy,
  output logic [WIDTH-1:0] out
);

  localparam int MAXC  = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  state_e             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic [2*WIDTH-1:0] r_res;
  logic               r_div_zero;

  logic               w_accept, w_commit;
  logic [2*WIDTH-1:0] w_a, w_b, w_prod, w_acc, w_mul_res;
  logic [WIDTH-1:0]   w_quot, w_rem;

  assign busy     = (r_state != S_IDLE);
  assign out      = rd_hi ? r_hi : r_lo;
  assign w_accept = start & ~busy & ~flush;

  // Product is formed at accept; the counter alone models multiply latency.
  assign w_a       = is_signed(op) ? {{WIDTH{src1[WIDTH-1]}}, src1} : {{WIDTH{1'b0}}, src1};
  assign w_b       = is_signed(op) ? {{WIDTH{src2[WIDTH-1]}}, src2} : {{WIDTH{1'b0}}, src2};
  assign w_prod    = w_a * w_b;
  assign w_acc     = {r_hi, r_lo};
  assign w_mul_res = !is_acc(op) ? w_prod : (is_sub(op) ? (w_acc - w_prod) : (w_acc + w_prod));

  seq_divider #(
    .WIDTH      (WIDTH),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_accept & is_div(op)),
    .i_signed   (is_signed(op)),
    .i_dividend (src1),
    .i_divisor  (src2),
    .o_quot     (w_quot),
    .o_rem      (w_rem)
  );

  // Next-state and commit decode; flush beats a same-cycle commit.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept && is_mul(op)) begin
          w_state_nxt = S_MUL;
          w_cnt_nxt   = MUL_LOAD;
        end else if (w_accept && is_div(op)) begin
          w_state_nxt = S_DIV;
          w_cnt_nxt   = DIV_LOAD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_MUL, S_DIV: begin
        if (flush) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = {CNT_W{1'b0}};
        end else if (r_cnt == {CNT_W{1'b0}}) begin
          w_state_nxt = S_IDLE;
          w_commit    = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = {CNT_W{1'b0}};
      end
    endcase
  end

  // FSM state and latency counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= {CNT_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Multiply result and divide-by-zero flag captured at accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_res      <= {(2*WIDTH){1'b0}};
      r_div_zero <= 1'b0;
    end else if (w_accept) begin
      r_res      <= w_mul_res;
      r_div_zero <= (src2 == {WIDTH{1'b0}});
    end else begin
      r_res      <= r_res;
      r_div_zero <= r_div_zero;
    end
  end

  // Architectural HI/LO: commits and moves are mutually exclusive since accept needs idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= {WIDTH{1'b0}};
      r_lo <= {WIDTH{1'b0}};
    end else if (w_commit && (r_state == S_MUL)) begin
      r_hi <= r_res[2*WIDTH-1:WIDTH];
      r_lo <= r_res[WIDTH-1:0];
    end else if (w_commit && (r_state == S_DIV) && !r_div_zero) begin
      r_hi <= w_rem;
      r_lo <= w_quot;
    end else if (w_accept && (op == OP_MTHI)) begin
      r_hi <= src1;
    end else if (w_accept && (op == OP_MTLO)) begin
      r_lo <= src1;
    end else begin
      r_hi <= r_hi;
      r_lo <= r_lo;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench: directed cases with literal expectations plus randomized traffic
// compared every cycle against an arithmetic model of HI/LO and busy.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic         clk = 1'b0;
  logic         reset, start, flush, rd_hi;
  logic [3:0]   op;
  logic [W-1:0] src1, src2;
  logic         busy;
  logic [W-1:0] out;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  int           m_busy = 0;
  bit           p_valid = 1'b0;

  muldiv_unit #(.WIDTH(W), .MUL_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .src1(src1), .src2(src2),
    .flush(flush), .rd_hi(rd_hi), .busy(busy), .out(out)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural behaviour of one clock edge, from the inputs the DUT sees.
  task automatic model_step();
    logic [2*W-1:0] p, t;
    longint a, b, q, r;
    if (reset) begin
      m_hi = '0; m_lo = '0; m_busy = 0; p_valid = 1'b0;
    end else if (m_busy > 0) begin
      if (flush) m_busy = 0;
      else begin
        m_busy--;
        if (m_busy == 0 && p_valid) begin m_hi = p_hi; m_lo = p_lo; end
      end
    end else if (start && !flush) begin
      case (op)
        OP_MTHI: m_hi = src1;
        OP_MTLO: m_lo = src1;
        OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
          if (op == OP_MULT || op == OP_MADD || op == OP_MSUB)
            p = longint'($signed(src1)) * longint'($signed(src2));
          else
            p = {32'd0, src1} * {32'd0, src2};
          t = {m_hi, m_lo};
          if (op == OP_MADD || op == OP_MADDU)      t = t + p;
          else if (op == OP_MSUB || op == OP_MSUBU) t = t - p;
          else                                      t = p;
          {p_hi, p_lo} = t;
          p_valid = 1'b1;
          m_busy  = MC;
        end
        OP_DIV, OP_DIVU: begin
          if (src2 == '0) p_valid = 1'b0;
          else begin
            if (op == OP_DIV) begin
              a = longint'($signed(src1)); b = longint'($signed(src2));
            end else begin
              a = longint'({32'd0, src1}); b = longint'({32'd0, src2});
            end
            q = a / b; r = a % b;
            p_lo = q[31:0]; p_hi = r[31:0];
            p_valid = 1'b1;
          end
          m_busy = DC;
        end
        default: ;
      endcase
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("busy", {{(W-1){1'b0}}, busy}, {{(W-1){1'b0}}, (m_busy != 0)});
    chk(rd_hi ? "out_hi" : "out_lo", out, rd_hi ? m_hi : m_lo);
  endtask

  task automatic check_hilo(input string name, input logic [W-1:0] eh, input logic [W-1:0] el);
    rd_hi = 1'b1; #1;
    chk({name, " hi"}, out, eh);
    chk({name, " model hi"}, m_hi, eh);
    rd_hi = 1'b0; #1;
    chk({name, " lo"}, out, el);
    chk({name, " model lo"}, m_lo, el);
  endtask

  task automatic wait_idle(output int nbusy);
    nbusy = 0;
    while (busy && nbusy < 100) begin
      nbusy++;
      cycle();
    end
    if (nbusy >= 100) chk("idle timeout", 32'd1, 32'd0);
  endtask

  task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int nbusy);
    op = o; src1 = a; src2 = b; start = 1'b1;
    cycle();
    start = 1'b0;
    wait_idle(nbusy);
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: rnd_operand = 32'h0000_0000;
      1: rnd_operand = 32'h0000_0001;
      2: rnd_operand = 32'hFFFF_FFFF;
      3: rnd_operand = 32'h8000_0000;
      4: rnd_operand = 32'h7FFF_FFFF;
      5: rnd_operand = 32'($urandom_range(0, 20));
      default: rnd_operand = $urandom;
    endcase
  endfunction

  initial begin
    int nb;
    reset = 1'b1; start = 1'b0; flush = 1'b0; rd_hi = 1'b0;
    op = 4'd0; src1 = '0; src2 = '0;
    cycle(); cycle();
    reset = 1'b0;
    cycle();
    check_hilo("reset", 32'h0, 32'h0);

    issue(OP_MULT, 32'hFFFF_FFFE, 32'h3, nb);
    chk("mult busy len", 32'(nb), 32'd5);
    check_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    issue(OP_MULTU, 32'hFFFF_FFFE, 32'h3, nb);
    check_hilo("multu", 32'h0000_0002, 32'hFFFF_FFFA);

    issue(OP_DIV, 32'hFFFF_FFF9, 32'h2, nb);
    chk("div busy len", 32'(nb), 32'd10);
    check_hilo("div -7/2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    issue(OP_DIVU, 32'd100, 32'd7, nb);
    check_hilo("divu 100/7", 32'h2, 32'hE);

    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, nb);
    check_hilo("div min/-1", 32'h0, 32'h8000_0000);

    issue(OP_MTHI, 32'd1, 32'd0, nb);
    chk("mthi busy len", 32'(nb), 32'd0);
    issue(OP_MTLO, 32'd2, 32'd0, nb);
    issue(OP_DIV, 32'd5, 32'd0, nb);
    chk("div0 busy len", 32'(nb), 32'd10);
    check_hilo("div by zero", 32'h1, 32'h2);

    issue(OP_MTLO, 32'd5, 32'd0, nb);
    issue(OP_MTHI, 32'd0, 32'd0, nb);
    issue(OP_MADD, 32'd2, 32'd3, nb);
    check_hilo("madd", 32'h0, 32'hB);

    // Flush during the third busy cycle of a multiply.
    op = OP_MULT; src1 = 32'd7; src2 = 32'd9; start = 1'b1;
    cycle();
    start = 1'b0;
    cycle(); cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("flush busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 6; i++) cycle();
    check_hilo("after flush", 32'h0, 32'hB);

    // Start while busy is ignored.
    op = OP_MULTU; src1 = 32'd2; src2 = 32'd2; start = 1'b1;
    cycle();
    op = OP_MTLO; src1 = 32'h55;
    cycle();
    start = 1'b0;
    wait_idle(nb);
    check_hilo("start while busy", 32'h0, 32'h4);

    // Reset in the middle of a divide.
    op = OP_DIV; src1 = 32'd100; src2 = 32'd3; start = 1'b1;
    cycle();
    start = 1'b0;
    cycle(); cycle(); cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("reset mid-div busy", {31'd0, busy}, 32'd0);
    check_hilo("reset mid-div", 32'h0, 32'h0);

    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      flush = ($urandom_range(0, 24) == 0);
      start = ($urandom_range(0, 2) != 0);
      op    = 4'($urandom_range(0, 11));
      src1  = rnd_operand();
      src2  = rnd_operand();
      rd_hi = $urandom_range(0, 1) != 0;
      cycle();
    end
    reset = 1'b0; flush = 1'b0; start = 1'b0;
    wait_idle(nb);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
